// File: rtl/udp_rx_pkt_buf.sv
// Purpose : store UDP payloads whole and replay only committed packets as a valid/ready byte stream.
// Latency : first out_valid 3 cycles after the commit cycle; no bubbles inside a packet, 2 idle cycles between packets.
// Backpres: out_ready stalls the reader only; the receive side never stalls, and packets that do not fit are dropped whole.
//
// Ports:
//   rgmii_clk, rst                : clock, asynchronous active-high reset
//   udp_rec_data_valid/rdata/length : receive byte stream; length is stable during a burst
//   out_valid/out_ready/out_data  : replay byte stream
//   out_sop/out_eop/out_len       : first/last byte flags, packet length (constant per packet)
//   drop_pulse/drop_cnt           : one pulse per dropped packet, saturating drop count
module udp_rx_pkt_buf #(
  parameter int DEPTH          = 2048,
  parameter int MAX_LEN        = 1472,
  parameter int LEN_FIFO_DEPTH = 16
) (
  input  logic        rgmii_clk,
  input  logic        rst,
  input  logic        udp_rec_data_valid,
  input  logic [7:0]  udp_rec_rdata,
  input  logic [15:0] udp_rec_data_length,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic [15:0] out_len,
  output logic        drop_pulse,
  output logic [15:0] drop_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int LAW = $clog2(LEN_FIFO_DEPTH);
  localparam int LPW = LAW + 1;
  localparam logic [PW-1:0]  DEPTH_P   = PW'(DEPTH);
  localparam logic [LPW-1:0] LF_FULL_P = LPW'(LEN_FIFO_DEPTH);
  localparam logic [15:0]    MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic {W_IDLE, W_RX} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  // Payload RAM, synchronous read
  logic [7:0]     r_ram [DEPTH];
  logic [7:0]     r_ram_q;

  // Committed-length FIFO
  logic [15:0]    r_lf_mem [LEN_FIFO_DEPTH];
  logic [LPW-1:0] r_lf_wp;
  logic [LPW-1:0] r_lf_rp;

  // Write side
  wstate_t        r_wstate;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_wr_commit;
  logic [15:0]    r_len;
  logic [15:0]    r_cnt;
  logic           r_bad;

  // Read side
  rstate_t        r_rstate;
  logic [PW-1:0]  r_rd_ptr;
  logic [15:0]    r_rem;

  logic [PW-1:0]  w_used;
  logic           w_space;
  logic           w_lf_empty;
  logic           w_lf_full;
  logic [15:0]    w_lf_dout;
  logic           w_first_bad;
  logic           w_bad_now;
  logic           w_we;
  logic           w_end;
  logic           w_commit;
  logic           w_drop;
  logic           w_hs;
  logic           w_re;
  logic [AW-1:0]  w_raddr;

  // Space is measured against rd_ptr, so bytes of a packet still being received
  // count as used but are invisible to the reader until committed.
  assign w_used      = r_wr_ptr - r_rd_ptr;
  assign w_space     = (w_used < DEPTH_P);
  assign w_lf_empty  = (r_lf_wp == r_lf_rp);
  assign w_lf_full   = ((r_lf_wp - r_lf_rp) == LF_FULL_P);
  assign w_lf_dout   = r_lf_mem[r_lf_rp[LAW-1:0]];

  // On the first byte the burst's bad flag is not yet registered, so evaluate it here.
  assign w_first_bad = (udp_rec_data_length == 16'd0) ||
                       (udp_rec_data_length > MAX_LEN_W) || w_lf_full;
  assign w_bad_now   = (r_wstate == W_IDLE) ? w_first_bad : r_bad;
  assign w_we        = udp_rec_data_valid && !w_bad_now && w_space;
  assign w_end       = (r_wstate == W_RX) && !udp_rec_data_valid;
  assign w_commit    = w_end && !r_bad && (r_cnt == r_len);
  assign w_drop      = w_end && !w_commit;
  assign w_hs        = out_valid && out_ready;

  // Read address: byte 0 from R_IDLE, byte 1 from R_FETCH, then always two ahead
  // of the presented byte so the next byte sits in r_ram_q at each handshake.
  always_comb begin
    w_re    = 1'b0;
    w_raddr = r_rd_ptr[AW-1:0];
    case (r_rstate)
      R_IDLE:  w_re = !w_lf_empty;
      R_FETCH: begin
        w_re    = 1'b1;
        w_raddr = r_rd_ptr[AW-1:0] + AW'(1);
      end
      R_DATA: begin
        w_re    = w_hs && (r_rem != 16'd1);
        w_raddr = r_rd_ptr[AW-1:0] + AW'(2);
      end
      default: w_re = 1'b0;
    endcase
  end

  // r_ram_q only updates on a read, so it holds the prefetched byte during stalls.
  always_ff @(posedge rgmii_clk) begin
    if (w_we) r_ram[r_wr_ptr[AW-1:0]] <= udp_rec_rdata;
    if (w_re) r_ram_q <= r_ram[w_raddr];
  end

  always_ff @(posedge rgmii_clk) begin
    if (w_commit) r_lf_mem[r_lf_wp[LAW-1:0]] <= r_len;
  end

  // Write FSM
  always_ff @(posedge rgmii_clk or posedge rst) begin
    if (rst) begin
      r_wstate    <= W_IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_bad       <= 1'b0;
      r_lf_wp     <= '0;
      drop_pulse  <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      drop_pulse <= 1'b0;
      if (w_we) r_wr_ptr <= r_wr_ptr + PW'(1);
      case (r_wstate)
        W_IDLE: begin
          if (udp_rec_data_valid) begin
            r_len    <= udp_rec_data_length;
            r_cnt    <= 16'd1;
            r_bad    <= !w_we;
            r_wstate <= W_RX;
          end
        end
        W_RX: begin
          if (udp_rec_data_valid) begin
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            if (!w_we) r_bad <= 1'b1;
          end else begin
            if (w_commit) begin
              r_wr_commit <= r_wr_ptr;
              r_lf_wp     <= r_lf_wp + LPW'(1);
            end else if (w_drop) begin
              r_wr_ptr   <= r_wr_commit;
              drop_pulse <= 1'b1;
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM with registered outputs
  always_ff @(posedge rgmii_clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_rd_ptr  <= '0;
      r_rem     <= '0;
      r_lf_rp   <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (!w_lf_empty) begin
            r_rem    <= w_lf_dout;
            out_len  <= w_lf_dout;
            r_lf_rp  <= r_lf_rp + LPW'(1);
            r_rstate <= R_FETCH;
          end
        end
        R_FETCH: begin
          out_data  <= r_ram_q;
          out_valid <= 1'b1;
          out_sop   <= 1'b1;
          out_eop   <= (r_rem == 16'd1);
          r_rstate  <= R_DATA;
        end
        R_DATA: begin
          if (w_hs) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_rem    <= r_rem - 16'd1;
            out_sop  <= 1'b0;
            if (r_rem == 16'd1) begin
              out_valid <= 1'b0;
              out_eop   <= 1'b0;
              r_rstate  <= R_IDLE;
            end else begin
              out_data <= r_ram_q;
              out_eop  <= (r_rem == 16'd2);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_pkt_buf.sv
module tb_udp_rx_pkt_buf;

  localparam int DEPTH   = 2048;
  localparam int MAX_LEN = 1472;
  localparam int LFD     = 16;

  logic        clk;
  logic        rst;
  logic        udp_rec_data_valid;
  logic [7:0]  udp_rec_rdata;
  logic [15:0] udp_rec_data_length;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic [15:0] out_len;
  logic        drop_pulse;
  logic [15:0] drop_cnt;

  udp_rx_pkt_buf #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .LEN_FIFO_DEPTH(LFD)) dut (
    .rgmii_clk           (clk),
    .rst                 (rst),
    .udp_rec_data_valid  (udp_rec_data_valid),
    .udp_rec_rdata       (udp_rec_rdata),
    .udp_rec_data_length (udp_rec_data_length),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .out_sop             (out_sop),
    .out_eop             (out_eop),
    .out_len             (out_len),
    .drop_pulse          (drop_pulse),
    .drop_cnt            (drop_cnt)
  );

  typedef struct {
    logic [7:0]  d;
    logic        sop;
    logic        eop;
    logic [15:0] len;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_drops = 0;
  int   seen_drops = 0;
  int   ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Consumer readiness
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks stall stability and no mid-packet gaps
  initial begin : mon
    exp_t        e;
    logic        prev_stall;
    logic        in_pkt;
    logic [25:0] p_beat;
    prev_stall = 1'b0;
    in_pkt     = 1'b0;
    p_beat     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        in_pkt     = 1'b0;
      end else begin
        if (drop_pulse) seen_drops++;
        if (prev_stall)
          chk("stall_hold", {out_valid, out_data, out_sop, out_eop, out_len}, {1'b1, p_beat});
        else if (in_pkt)
          chk("no_mid_packet_gap", out_valid, 1'b1);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got data 0x%0h len %0d, required no output", out_data, out_len);
          end else begin
            e = sb.pop_front();
            chk("out_beat{data,sop,eop,len}", {out_data, out_sop, out_eop, out_len},
                {e.d, e.sop, e.eop, e.len});
          end
          in_pkt = !out_eop;
        end
        prev_stall = out_valid && !out_ready;
        p_beat     = {out_data, out_sop, out_eop, out_len};
      end
    end
  end

  // Sends n bytes with length field l. The packet is expected out iff the caller
  // says it fits in the buffer and the length rules hold; otherwise one drop.
  task automatic send_pkt(input logic [15:0] l, input int n, input bit fits, input bit incr);
    logic [7:0] pl[$];
    exp_t       e;
    bit         good;
    for (int i = 0; i < n; i++) pl.push_back(incr ? 8'(i + 1) : 8'($urandom));
    good = fits && (l != 0) && (int'(l) <= MAX_LEN) && (n == int'(l));
    if (good) begin
      for (int i = 0; i < n; i++) begin
        e.d = pl[i]; e.sop = (i == 0); e.eop = (i == n - 1); e.len = l;
        sb.push_back(e);
      end
    end else begin
      exp_drops++;
    end
    for (int i = 0; i < n; i++) begin
      udp_rec_data_valid  = 1'b1;
      udp_rec_rdata       = pl[i];
      udp_rec_data_length = l;
      @(posedge clk);
      #1;
    end
    udp_rec_data_valid = 1'b0;
    udp_rec_rdata      = 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d bytes outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_drops(input string nm);
    chk({nm, "_drop_cnt"}, drop_cnt, exp_drops);
    chk({nm, "_drop_pulses"}, seen_drops, exp_drops);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_valid_sop_eop_pulse"}, {out_valid, out_sop, out_eop, drop_pulse}, 4'b0000);
    chk({nm, "_data"}, out_data, 8'h00);
    chk({nm, "_len"}, out_len, 16'h0000);
    chk({nm, "_drop_cnt"}, drop_cnt, 16'h0000);
  endtask

  initial begin : stim
    int          c_commit;
    int          lat;
    int          w;
    int          npk;
    int          kind;
    int          n;
    logic [15:0] l;

    rst                 = 1'b1;
    udp_rec_data_valid  = 1'b0;
    udp_rec_rdata       = 8'h00;
    udp_rec_data_length = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single packet with latency bound
    ready_mode = 1;
    send_pkt(16'd8, 8, 1'b1, 1'b1);
    c_commit = cyc - 1;
    w = 0;
    lat = 0;
    while (w < 12) begin
      @(negedge clk);
      w++;
      if (out_valid) begin
        lat = cyc - c_commit;
        break;
      end
    end
    n_tests++;
    if (!out_valid || lat > 3 || lat < 1) begin
      n_fail++;
      $display("FAIL first_valid_latency: got %0d cycles (valid=%0b), required <= 3", lat, out_valid);
    end
    @(posedge clk);
    #1;
    wait_drain(200);
    check_drops("single");

    // Length rule violations followed by a good packet
    send_pkt(16'd6, 5, 1'b1, 1'b0);
    send_pkt(16'd4, 4, 1'b1, 1'b0);
    wait_drain(200);
    check_drops("mismatch");
    send_pkt(16'd0, 3, 1'b1, 1'b0);
    send_pkt(16'(MAX_LEN + 1), 4, 1'b1, 1'b0);
    send_pkt(16'd3, 5, 1'b1, 1'b0);
    send_pkt(16'(MAX_LEN), MAX_LEN, 1'b1, 1'b0);
    wait_drain(4000);
    check_drops("bad_len");

    // Back-to-back with random backpressure
    ready_mode = 2;
    send_pkt(16'd1, 1, 1'b1, 1'b0);
    send_pkt(16'd1472, 1472, 1'b1, 1'b0);
    send_pkt(16'd3, 3, 1'b1, 1'b0);
    wait_drain(10000);
    check_drops("backpressure");

    // Overflow: B cannot fit behind A while the reader is stalled
    ready_mode = 0;
    send_pkt(16'd1472, 1472, 1'b1, 1'b0);
    send_pkt(16'd1000, 1000, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    ready_mode = 1;
    wait_drain(4000);
    check_drops("overflow");
    send_pkt(16'd16, 16, 1'b1, 1'b1);
    wait_drain(200);

    // Length FIFO full: reader holds packet 1, FIFO takes the next 16, the 18th drops
    ready_mode = 0;
    for (int i = 0; i < 18; i++) send_pkt(16'd2, 2, (i < 17), 1'b0);
    repeat (5) @(posedge clk);
    #1;
    ready_mode = 1;
    wait_drain(1000);
    check_drops("lenfifo_full");

    // Randomized bursts; each burst stays well inside the byte and packet capacity
    ready_mode = 2;
    for (int b = 0; b < 10; b++) begin
      npk = $urandom_range(1, 4);
      for (int p = 0; p < npk; p++) begin
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          l = 16'd0; n = $urandom_range(1, 20);
        end else if (kind == 1) begin
          l = 16'(MAX_LEN + 1 + $urandom_range(0, 100)); n = $urandom_range(1, 20);
        end else if (kind == 2) begin
          l = 16'($urandom_range(2, 200));
          n = ($urandom_range(0, 1) != 0) ? int'(l) + 1 : int'(l) - 1;
        end else begin
          l = 16'($urandom_range(1, 200)); n = int'(l);
        end
        send_pkt(l, n, 1'b1, 1'b0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
      end
      wait_drain(4000);
      check_drops("random");
    end

    // Reset mid-packet while a previous packet is being read out
    ready_mode = 1;
    send_pkt(16'd10, 10, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      udp_rec_data_valid  = 1'b1;
      udp_rec_rdata       = 8'(8'hA0 + i);
      udp_rec_data_length = 16'd10;
      if (i == 2) begin
        #2;
        rst = 1'b1;
        sb.delete();
        exp_drops  = 0;
        seen_drops = 0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    check_reset_outputs("midpkt_reset");
    udp_rec_data_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_pkt(16'd4, 4, 1'b1, 1'b1);
    wait_drain(200);
    check_drops("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
